seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed scan controller for the board's multi-digit seven-segment display. It holds a frame of hex nibbles and decimal-point flags, steps through the digits one at a time, and drives the active-low anode lines. For the selected digit it presents `number`/`dec_point` to `seven_seg_decoder`, which produces the cathodes. It adds an inter-digit blanking window against ghosting, tear-free frame updates, per-digit enables and leading-zero suppression.

## Interface
- `NUM_DIGITS`, 8, number of digits scanned (2..8).
- `REFRESH_DIV`, 100000, clock cycles per digit slot (1 ms at 100 MHz).
- `BLANK_CYCLES`, 1000, cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-high.
- `reset`  in  1  asynchronous, active-high reset.
- `value`  in  4*NUM_DIGITS  nibbles; bits [3:0] = digit 0 (rightmost, least significant).
- `dp_mask`  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- `enable_mask`  in  NUM_DIGITS  1 = digit may light; sampled live.
- `lz_blank`  in  1  leading-zero suppression enable; sampled live.
- `load`  in  1  single-cycle strobe; captures `value`/`dp_mask`.
- `number`  out  4  nibble of the current digit, to the decoder.
- `dec_point`  out  1  dp flag of the current digit, to the decoder.
- `anode`  out  NUM_DIGITS  active-low digit enables.
- `digit_idx`  out  3  index of the current digit.
- `frame_done`  out  1  one-cycle pulse at the start of each new frame.

## Operation
- Registers:
  - slot counter `cnt`, 0..REFRESH_DIV-1.
  - digit index `idx`, 0..NUM_DIGITS-1.
  - active frame `act_val`/`act_dp`.
  - shadow frame `sh_val`/`sh_dp`.
  - `pending` flag.
- Two-phase slot, selected by `cnt`:
  - BLANK (cnt < BLANK_CYCLES): `anode` = all ones.
  - SHOW (cnt ≥ BLANK_CYCLES): `anode[idx]` = 0, other bits 1, unless digit `idx` is suppressed, in which case all ones.
- Advance:
  - When cnt == REFRESH_DIV-1, cnt → 0 and idx → idx+1.
  - idx wraps NUM_DIGITS-1 → 0; the wrap is the frame boundary.
  - Otherwise cnt increments.
- `number`/`dec_point`/`digit_idx` are registered. They take the new digit's active nibble/dp on the same edge that starts its slot (BLANK phase), so the decoder settles before the anode turns on.
- Load path:
  - `load` = 1 copies `value`/`dp_mask` into the shadow and sets `pending`.
  - A later `load` before the boundary overwrites the shadow.
- Frame boundary edge:
  - If `load` is high on that cycle, the active frame takes `value`/`dp_mask` directly.
  - Else, if `pending` is set, the active frame takes the shadow.
  - `pending` clears in both cases.
  - The new active data is what appears on `number` for digit 0 at that edge. The active frame never changes mid-frame.
- Suppression of digit i, evaluated on the active frame:
  - `enable_mask[i]` = 0, or
  - `lz_blank` = 1, i > 0, and for every j with i ≤ j ≤ NUM_DIGITS-1: nibble j == 0 and `act_dp[j]` == 0.
  - Digit 0 is never leading-zero blanked.
  - A suppressed digit still occupies its full slot with all anodes high, so scan timing stays constant.
- `frame_done` is asserted for exactly the cycle in which cnt == 0 and idx == 0 after a wrap. It does not assert after reset.

## Timing
- Reset (asynchronous, immediate):
  - cnt = 0, idx = 0, `digit_idx` = 0.
  - `anode` = all ones, `number` = 0, `dec_point` = 0, `frame_done` = 0.
  - Active and shadow frames = 0, `pending` = 0.
- After reset deasserts, the first edge begins counting; digit 0 lights at cnt == BLANK_CYCLES.
- Slot length is exactly REFRESH_DIV cycles: BLANK_CYCLES dark, then REFRESH_DIV-BLANK_CYCLES lit.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- `load` latency to display is 1 to NUM_DIGITS*REFRESH_DIV cycles, taking effect at the next frame boundary edge.
- Reset mid-slot or mid-frame aborts immediately: anodes go dark, the pending load is lost, and the scan restarts at digit 0.
- `enable_mask`/`lz_blank` changes affect the anode from the next edge. They may cut a SHOW phase short; timing does not change.

## Test plan
- Reset, with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1: hold `reset` high → `anode`=4'b1111, `number`=0, `dec_point`=0, `frame_done`=0; assert `reset` asynchronously between edges → outputs clear without a clock edge.
- Scan order (same parameters), load value=16'h4321, dp_mask=4'b0100 before the first wrap → from the frame after the wrap, per digit: 1 cycle `anode`=1111, then 3 cycles with `anode`=1110/1101/1011/0111 in turn, `number`=1,2,3,4, `dec_point` high only for digit 2; `frame_done` pulses every 16 cycles.
- Deferred load: in the middle of digit 1, strobe load with value=16'hAAAA, then strobe again with 16'h5555 in digit 2 → digits 2 and 3 still show the old frame; from the boundary, all digits show 5; `pending` clears.
- Simultaneous load and boundary: strobe load with 16'h0F0F on the wrap cycle → digit 0 shows `number`=F on that same edge.
- Leading-zero blanking: active 16'h0010, dp_mask=0, lz_blank=1 → digits 3 and 2 stay dark for their whole slots, digits 1 and 0 light; set dp_mask[3]=1 → digits 3 and 2 light again.
- Enable mask and reset mid-operation: enable_mask=4'b1010 → digits 0 and 2 stay dark with slot timing unchanged; assert reset during the SHOW phase of digit 2 → anodes dark immediately, scan restarts at digit 0, and display returns to 0.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: frame-load inputs and digit-drive outputs of the seven-segment scanner
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   enable_mask;
    logic                    lz_blank;
    logic                    load;
    logic [3:0]              number;
    logic                    dec_point;
    logic [NUM_DIGITS-1:0]   anode;
    logic [2:0]              digit_idx;
    logic                    frame_done;

    modport master (
        output value, dp_mask, enable_mask, lz_blank, load,
        input  number, dec_point, anode, digit_idx, frame_done
    );

    modport slave (
        input  value, dp_mask, enable_mask, lz_blank, load,
        output number, dec_point, anode, digit_idx, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed digit scanner with blanking, tear-free frame loads and zero suppression
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic clk,
    input logic reset,
    seven_seg_scanner_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt, cnt_n;
    logic [2:0]              idx, idx_n;
    logic [4*NUM_DIGITS-1:0] act_val, act_val_n, sh_val;
    logic [NUM_DIGITS-1:0]   act_dp, act_dp_n, sh_dp;
    logic                    pending;
    logic                    last_slot, wrap, zero_run, supp_sel;
    logic [NUM_DIGITS-1:0]   supp, anode_n;

    always_comb begin
        last_slot = cnt == CNT_LAST;
        wrap = last_slot && idx == IDX_LAST;
        cnt_n = last_slot ? '0 : cnt + 1'b1;
        idx_n = wrap ? '0 : last_slot ? idx + 1'b1 : idx;
        act_val_n = !wrap ? act_val : bus.load ? bus.value : pending ? sh_val : act_val;
        act_dp_n = !wrap ? act_dp : bus.load ? bus.dp_mask : pending ? sh_dp : act_dp;
        // walk down from the top digit so zero_run means "this and every higher digit is blank"
        zero_run = 1'b1;
        supp = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (act_val[4*i +: 4] == 4'h0) & ~act_dp[i];
            supp[i] = ~bus.enable_mask[i] | (bus.lz_blank & zero_run & (i != 0));
        end
        supp_sel = 1'(supp >> idx_n);
        anode_n = (cnt_n < BLANK_C || supp_sel) ? '1 : ~(NUM_DIGITS'(1) << idx_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            idx            <= '0;
            act_val        <= '0;
            act_dp         <= '0;
            sh_val         <= '0;
            sh_dp          <= '0;
            pending        <= 1'b0;
            bus.anode      <= '1;
            bus.number     <= '0;
            bus.dec_point  <= 1'b0;
            bus.digit_idx  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            idx     <= idx_n;
            act_val <= act_val_n;
            act_dp  <= act_dp_n;
            if (bus.load) begin
                sh_val <= bus.value;
                sh_dp  <= bus.dp_mask;
            end
            pending        <= !wrap && (pending || bus.load);
            bus.anode      <= anode_n;
            bus.number     <= 4'(act_val_n >> {idx_n, 2'b00});
            bus.dec_point  <= 1'(act_dp_n >> idx_n);
            bus.digit_idx  <= idx_n;
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: table vectors, directed corner sequences and random stimulus against a slot-arithmetic model
module tb_seven_seg_scanner;
    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 1;
    localparam int NR = N * R;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
        logic [15:0] show;
    } vec_t;

    logic clk = 0;
    logic reset = 1;
    int k = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] m_val = '0, m_sh = '0;
    logic [3:0]  m_dp = '0, m_shdp = '0;
    bit          m_pend = 0;
    vec_t        vecs[7];

    seven_seg_scanner_if #(.NUM_DIGITS(N)) bus();

    seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {bus.anode, bus.number, bus.dec_point, bus.digit_idx, bus.frame_done};
    endfunction

    // Position in the frame follows from the edge count alone: slot = k/R, phase = k%R.
    function automatic logic [12:0] model_out();
        int p, d, s;
        logic dark;
        p = k % NR;
        d = p / R;
        s = p % R;
        dark = s < B || !bus.enable_mask[d] ||
               (bus.lz_blank && d > 0 && (m_val >> (4 * d)) == 0 && (m_dp >> d) == 0);
        return {dark ? 4'hF : ~(4'b0001 << d), m_val[4*d +: 4], m_dp[d], 3'(d), k > 0 && p == 0};
    endfunction

    task automatic tick();
        @(posedge clk);
        k++;
        if (k % NR == 0) begin
            if (bus.load) begin
                m_val = bus.value;
                m_dp = bus.dp_mask;
            end else if (m_pend) begin
                m_val = m_sh;
                m_dp = m_shdp;
            end
            m_pend = 0;
        end else if (bus.load) begin
            m_sh = bus.value;
            m_shdp = bus.dp_mask;
            m_pend = 1;
        end
        #1;
        chk($sformatf("model_k%0d", k), 32'(outs()), 32'(model_out()));
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        k = 0;
        m_val = '0;
        m_dp = '0;
        m_sh = '0;
        m_shdp = '0;
        m_pend = 0;
    endtask

    task automatic strobe(input logic [15:0] v, input logic [3:0] dp);
        bus.value = v;
        bus.dp_mask = dp;
        bus.load = 1;
        tick();
        bus.load = 0;
    endtask

    initial begin
        vecs[0] = '{16'h4321, 4'b0100, 4'hF, 1'b0, 16'h7BDE};
        vecs[1] = '{16'h0010, 4'b0000, 4'hF, 1'b1, 16'hFFDE};
        vecs[2] = '{16'h0010, 4'b1000, 4'hF, 1'b1, 16'h7BDE};
        vecs[3] = '{16'h1234, 4'b0000, 4'b1010, 1'b0, 16'h7FDF};
        vecs[4] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 16'hFFFE};
        vecs[5] = '{16'h0000, 4'b0000, 4'h0, 1'b0, 16'hFFFF};
        vecs[6] = '{16'h0500, 4'b0000, 4'hF, 1'b1, 16'hFBDE};
        bus.value = '0;
        bus.dp_mask = '0;
        bus.enable_mask = 4'hF;
        bus.lz_blank = 0;
        bus.load = 0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_anode", 32'(bus.anode), 32'hF);
        chk("rst_number", 32'(bus.number), 0);
        chk("rst_dp", 32'(bus.dec_point), 0);
        chk("rst_idx", 32'(bus.digit_idx), 0);
        chk("rst_fd", 32'(bus.frame_done), 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            bus.enable_mask = vecs[i].en;
            bus.lz_blank = vecs[i].lz;
            strobe(vecs[i].value, vecs[i].dp);
            run_to(NR);
            for (int c = 0; c < NR; c++) begin
                int d, s;
                if (c > 0) tick();
                d = c / R;
                s = c % R;
                chk($sformatf("vec%0d_c%0d", i, c), 32'(outs()),
                    32'({s == 0 ? 4'hF : vecs[i].show[4*d +: 4], vecs[i].value[4*d +: 4],
                         vecs[i].dp[d], 3'(d), c == 0}));
            end
        end

        do_reset();
        bus.enable_mask = 4'hF;
        bus.lz_blank = 0;
        strobe(16'h7777, 4'h0);
        run_to(22);
        strobe(16'hAAAA, 4'h0);
        run_to(25);
        strobe(16'h5555, 4'h0);
        run_to(27);
        chk("defer_d2_num", 32'(bus.number), 32'h7);
        run_to(29);
        chk("defer_d3_num", 32'(bus.number), 32'h7);
        chk("defer_d3_anode", 32'(bus.anode), 32'h7);
        run_to(32);
        chk("defer_new_num", 32'(bus.number), 32'h5);
        chk("defer_fd", 32'(bus.frame_done), 1);
        run_to(37);
        chk("defer_d1_num", 32'(bus.number), 32'h5);
        chk("defer_d1_anode", 32'(bus.anode), 32'hD);

        run_to(47);
        strobe(16'h0F0F, 4'h0);
        chk("sim_num", 32'(bus.number), 32'hF);
        chk("sim_idx", 32'(bus.digit_idx), 0);
        chk("sim_anode", 32'(bus.anode), 32'hF);
        bus.enable_mask = 4'b1010;
        run_to(50);
        chk("en_d0_dark", 32'(bus.anode), 32'hF);
        run_to(54);
        chk("en_d1_lit", 32'(bus.anode), 32'hD);
        run_to(58);
        chk("en_d2_dark", 32'(bus.anode), 32'hF);
        chk("en_d2_idx", 32'(bus.digit_idx), 2);
        run_to(62);
        chk("en_d3_lit", 32'(bus.anode), 32'h7);
        bus.enable_mask = 4'hF;
        run_to(69);
        strobe(16'h1234, 4'h0);
        run_to(74);
        chk("pre_rst_anode", 32'(bus.anode), 32'hB);
        chk("pre_rst_num", 32'(bus.number), 32'hF);
        #2;
        reset = 1;
        #1;
        chk("async_anode", 32'(bus.anode), 32'hF);
        chk("async_idx", 32'(bus.digit_idx), 0);
        chk("async_num", 32'(bus.number), 0);
        do_reset();
        run_to(10);
        chk("post_rst_num", 32'(bus.number), 0);
        chk("post_rst_anode", 32'(bus.anode), 32'hB);
        run_to(17);
        chk("pend_lost", 32'(bus.number), 0);

        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 19) == 0) bus.enable_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) bus.lz_blank = ~bus.lz_blank;
            if ($urandom_range(0, 7) == 0) begin
                bus.value = 16'($urandom) >> (4 * $urandom_range(0, 4));
                bus.dp_mask = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
                bus.load = 1;
            end
            tick();
            bus.load = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
